// File: rtl/count_pkg.sv
// Shared types and default widths for the counter snapshot block.
// The snapshot word is {extension, count}, with the extension in the high part.
package count_pkg;

  localparam int CW_DEF = 8;
  localparam int EW_DEF = 8;
  localparam int SW_DEF = CW_DEF + EW_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } state_e;

  typedef struct packed {
    logic [EW_DEF-1:0] ext;
    logic [CW_DEF-1:0] count;
  } snap_t;

endpackage

// File: rtl/count_snapshot_if.sv
// Valid/ready snapshot stream from count_snapshot to the readout logic.
interface count_snapshot_if #(
  parameter int SW = 16
) ();

  logic [SW-1:0] snap_data;
  logic          snap_valid;
  logic          snap_ready;

  modport master (output snap_data, output snap_valid, input snap_ready);
  modport slave  (input snap_data, input snap_valid, output snap_ready);

endinterface

// File: rtl/snap_fifo.sv
// First-word-fall-through FIFO for snapshots; the head reads as zero when empty.
// A push into a full FIFO succeeds only if a pop happens in the same cycle.
module snap_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // The extra MSB on each pointer separates full from empty.
  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; the pointers define what is valid, and the
  // empty-case zero is produced on the read side instead.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/count_snapshot.sv
// Reads the up/down counter bus on request, extends it with a carry-driven
// high byte and queues {ext, count} snapshots for the readout logic.
module count_snapshot
  import count_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int EW    = EW_DEF,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr,
  input  logic [CW-1:0]     cnt_bus,
  input  logic              cnt_carry,
  output logic              rdb,
  count_snapshot_if.master  snap,
  output logic              busy,
  output logic              fifo_full,
  output logic              ext_ovf,
  output logic              drop
);

  localparam int SW = CW + EW;

  state_e        state_q;
  logic          rdb_q;
  logic          carry_q;
  logic [EW-1:0] ext_q, ext_d;
  logic          ext_ovf_q, ext_ovf_d;
  logic          drop_q, drop_d;
  logic          carry_rise, push, pop, fifo_empty;
  logic [SW-1:0] head;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdb_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= DRIVE;
          rdb_q   <= 1'b0;
        end
        DRIVE:  state_q <= SAMPLE;
        SAMPLE: begin
          state_q <= IDLE;
          rdb_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          rdb_q   <= 1'b1;
        end
      endcase
    end
  end

  // The bus is only looked at in SAMPLE, so a floating bus never leaks in.
  assign push       = (state_q == SAMPLE);
  assign pop        = !fifo_empty && snap.snap_ready;
  assign carry_rise = cnt_carry && !carry_q;

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    ext_d     = ext_q;
    ext_ovf_d = ext_ovf_q;
    drop_d    = drop_q;
    if (clr) begin
      ext_d     = '0;
      ext_ovf_d = 1'b0;
      drop_d    = 1'b0;
    end else begin
      if (carry_rise) begin
        ext_d = ext_q + EW'(1);
        if (&ext_q) ext_ovf_d = 1'b1;
      end
      if (push && fifo_full && !pop) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q   <= 1'b0;
      ext_q     <= '0;
      ext_ovf_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      carry_q   <= cnt_carry;
      ext_q     <= ext_d;
      ext_ovf_q <= ext_ovf_d;
      drop_q    <= drop_d;
    end
  end

  snap_fifo #(
    .W     (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({ext_q, cnt_bus}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign snap.snap_data  = head;
  assign snap.snap_valid = !fifo_empty;
  assign rdb             = rdb_q;
  assign busy            = (state_q != IDLE);
  assign ext_ovf         = ext_ovf_q;
  assign drop            = drop_q;

endmodule

// File: tb/tb_count_snapshot.sv
// Directed test of count_snapshot: expected snapshots go into a queue that a
// separate monitor drains whenever the DUT hands over an entry.
module tb_count_snapshot;
  import count_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic       cnt_carry = 1'b0;
  logic [7:0] cnt_bus = '0;
  logic       rdb, busy, fifo_full, ext_ovf, drop;

  count_snapshot_if #(.SW(SW_DEF)) snap ();

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  exp_ext = '0;
  logic [15:0] mon_want;

  always #5 clk = ~clk;

  count_snapshot #(.CW(8), .EW(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clr       (clr),
    .cnt_bus   (cnt_bus),
    .cnt_carry (cnt_carry),
    .rdb       (rdb),
    .snap      (snap),
    .busy      (busy),
    .fifo_full (fifo_full),
    .ext_ovf   (ext_ovf),
    .drop      (drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each negedge with valid&ready is one transfer at the next posedge.
  always @(negedge clk) begin
    if (rst && snap.snap_valid && snap.snap_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL snap_unexpected: got %0h, expected nothing", snap.snap_data);
      end else begin
        mon_want = exp_q.pop_front();
        if (snap.snap_data !== mon_want) begin
          errors++;
          $display("FAIL snap_data: got %0h, expected %0h", snap.snap_data, mon_want);
        end
      end
    end
  end

  task automatic snap_req(input logic [7:0] bus, input bit keep);
    cnt_bus = bus;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("rdb_drive", rdb, 1'b0);
    check("busy_drive", busy, 1'b1);
    tick();
    check("rdb_sample", rdb, 1'b0);
    if (keep) exp_q.push_back({exp_ext, bus});
    tick();
    check("rdb_idle", rdb, 1'b1);
    check("busy_idle", busy, 1'b0);
    cnt_bus = '0;
  endtask

  task automatic carry_pulse(input int len);
    cnt_carry = 1'b1;
    repeat (len) tick();
    cnt_carry = 1'b0;
    tick();
    exp_ext = exp_ext + 8'd1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    snap.snap_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    snap.snap_ready = 1'b0;
    check({name, "_drain_in_time"}, 32'(n < 40), 32'd1);
    check({name, "_empty_after_drain"}, snap.snap_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    snap.snap_ready = 1'b0;

    // Reset state
    #12;
    check("rst_rdb", rdb, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", snap.snap_valid, 1'b0);
    check("rst_data", snap.snap_data, 16'h0000);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", ext_ovf, 1'b0);
    check("rst_drop", drop, 1'b0);
    rst = 1'b1;
    tick();

    // Basic snapshot latency
    snap_req(8'h3C, 1'b1);
    check("t1_valid", snap.snap_valid, 1'b1);
    check("t1_data", snap.snap_data, 16'h003C);
    drain("t1");

    // Carry edges: three single pulses plus one held 3 cycles -> ext=4
    repeat (3) carry_pulse(1);
    carry_pulse(3);
    snap_req(8'h05, 1'b1);
    check("t2_data", snap.snap_data, 16'h0405);
    drain("t2");

    // Carry edge coinciding with SAMPLE uses pre-increment ext
    repeat (3) carry_pulse(1);
    cnt_bus = 8'h00;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cnt_carry = 1'b1;
    exp_q.push_back({exp_ext, 8'h00});
    tick();
    cnt_carry = 1'b0;
    exp_ext   = exp_ext + 8'd1;
    tick();
    check("t3_data", snap.snap_data, 16'h0700);
    snap_req(8'h11, 1'b1);
    drain("t3");

    // Fill, overflow drop, drain order, clear
    for (int i = 1; i <= 5; i++) begin
      snap_req(8'(i), i <= 4);
      if (i == 4) begin
        check("t4_full", fifo_full, 1'b1);
        check("t4_no_drop", drop, 1'b0);
      end
      if (i == 5) begin
        check("t4_drop", drop, 1'b1);
        check("t4_still_full", fifo_full, 1'b1);
      end
    end
    drain("t4");
    check("t4_not_full", fifo_full, 1'b0);
    check("t4_drop_sticky", drop, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_ext = '0;
    check("t4_drop_clr", drop, 1'b0);

    // Extension wrap and clr priority over carry
    repeat (255) carry_pulse(1);
    snap_req(8'hAA, 1'b1);
    check("t5_no_ovf", ext_ovf, 1'b0);
    drain("t5a");
    carry_pulse(1);
    check("t5_ovf", ext_ovf, 1'b1);
    snap_req(8'h33, 1'b1);
    drain("t5b");
    carry_pulse(1);
    cnt_carry = 1'b1;
    clr       = 1'b1;
    tick();
    cnt_carry = 1'b0;
    clr       = 1'b0;
    tick();
    exp_ext = '0;
    check("t5_ovf_clr", ext_ovf, 1'b0);
    snap_req(8'h44, 1'b1);
    drain("t5c");

    // Async reset during DRIVE, then start held while busy
    snap_req(8'h66, 1'b0);
    check("t6_valid_pre", snap.snap_valid, 1'b1);
    cnt_bus = 8'h77;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("t6_rdb_drive", rdb, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_rdb", rdb, 1'b1);
    check("t6_rst_valid", snap.snap_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_full", fifo_full, 1'b0);
    #2 rst = 1'b1;
    tick();
    exp_ext = '0;
    cnt_bus = 8'h88;
    start   = 1'b1;
    tick();
    check("t6_busy", busy, 1'b1);
    exp_q.push_back({exp_ext, 8'h88});
    tick();
    tick();
    start = 1'b0;
    check("t6_idle", busy, 1'b0);
    tick();
    tick();
    check("t6_no_retrigger", busy, 1'b0);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
